// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Instruction sequencer for the single-issue MIPS core. Holds the program
// counter, fetches one 32-bit instruction word at a time from instruction
// memory over a request/valid handshake, presents the latched word and its
// opcode field to the control decoder, and computes the next PC from the
// decoder's Branch/Jump outputs and the ALU Zero flag.
//
// Build option:
//   SEQ_PERF_CNT_EN  - when defined, retired_cnt counts retired instructions
//                      (EXEC->FETCH transitions, wrapping at 2^32). When
//                      undefined, no counter exists and retired_cnt is 0.
//
// Parameters:
//   RESET_PC     PC loaded on reset (word aligned).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request, high for the whole FETCH state
//   imem_addr    fetch address (always equal to pc)
//   imem_valid   instruction memory data valid (honoured only in FETCH)
//   imem_rdata   instruction word, captured on imem_req && imem_valid
//   pc           address of the current instruction
//   instr        latched instruction word
//   Opcode       instr[31:26], to the control decoder
//   instr_valid  high while instr/Opcode are presented for execution
//   exec_done    datapath finished the current instruction (honoured in EXEC)
//   Branch       branch request from the control decoder
//   Jump         jump request from the control decoder (wins over Branch)
//   Zero         ALU equality flag
//   retired_cnt  retired-instruction count
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  Opcode,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic        req_r;
    logic        ivalid_r;
    logic [31:0] next_pc_s;
    logic        retire_s;

    // Next-PC selection. All additions are 32-bit modular; Jump outranks a
    // taken branch, and the branch displacement is relative to pc + 4.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] cur_pc,
        input logic [31:0] word,
        input logic        br,
        input logic        jp,
        input logic        zr
    );
        logic [31:0] plus4;
        logic [31:0] result;
        plus4 = cur_pc + 32'd4;
        if (jp) begin
            result = {plus4[31:28], word[25:0], 2'b00};
        end else if (br && zr) begin
            result = plus4 + {{14{word[15]}}, word[15:0], 2'b00};
        end else begin
            result = plus4;
        end
        return result;
    endfunction

    // Next PC and retire strobe for the current EXEC cycle.
    always_comb begin
        next_pc_s = calc_next_pc(pc_r, instr_r, Branch, Jump, Zero);
        if (state_r == ST_EXEC) begin
            retire_s = exec_done;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Sequencer FSM with registered handshake outputs. imem_req/instr_valid
    // are set alongside the state they belong to, so they never depend on
    // inputs in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            instr_r  <= 32'h0000_0000;
            req_r    <= 1'b0;
            ivalid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r  <= ST_FETCH;
                    req_r    <= 1'b1;
                    ivalid_r <= 1'b0;
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr_r  <= imem_rdata;
                        state_r  <= ST_EXEC;
                        req_r    <= 1'b0;
                        ivalid_r <= 1'b1;
                    end else begin
                        state_r  <= ST_FETCH;
                        req_r    <= 1'b1;
                        ivalid_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc_r     <= next_pc_s;
                        state_r  <= ST_FETCH;
                        req_r    <= 1'b1;
                        ivalid_r <= 1'b0;
                    end else begin
                        state_r  <= ST_EXEC;
                        req_r    <= 1'b0;
                        ivalid_r <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: recover through IDLE.
                    state_r  <= ST_IDLE;
                    req_r    <= 1'b0;
                    ivalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign Opcode      = instr_r[31:26];
    assign instr_valid = ivalid_r;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt_r;

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_r <= 32'h0000_0000;
        end else if (retire_s) begin
            retired_cnt_r <= retired_cnt_r + 32'd1;
        end else begin
            retired_cnt_r <= retired_cnt_r;
        end
    end

    assign retired_cnt = retired_cnt_r;
`else
    assign retired_cnt = {31'd0, retire_s & 1'b0};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  Opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic [31:0] retired_cnt;

    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] model_pc;
    logic [31:0] model_ret;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .Opcode      (Opcode),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .Branch      (Branch),
        .Jump        (Jump),
        .Zero        (Zero),
        .retired_cnt (retired_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference next-PC from the ISA rules, using wide integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic br, input logic jp, input logic zr);
        longint seq;
        longint off;
        logic [31:0] region;
        seq = longint'(cur) + 64'd4;
        region = 32'(seq) & 32'hF000_0000;
        if (jp) return region | ({6'd0, word[25:0]} * 32'd4);
        if (br && zr) begin
            off = longint'($signed(word[15:0])) * 64'd4;
            return 32'(seq + off);
        end
        return 32'(seq);
    endfunction

    function automatic logic [31:0] exp_ret();
`ifdef SEQ_PERF_CNT_EN
        return model_ret;
`else
        return 32'h0000_0000;
`endif
    endfunction

    // Drive one instruction through FETCH and EXEC. Entered and left just after
    // a negedge; reports how many sampled cycles imem_req and instr_valid were high.
    task automatic run_instr(input logic [31:0] word, input logic br, input logic jp, input logic zr,
                             input int fwait, input int ewait, output int req_hi, output int iv_hi);
        int guard;
        req_hi = 0;
        iv_hi  = 0;
        guard  = 0;
        while (imem_req !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_timeout: imem_req=%b required 1", imem_req);
        end
        req_hi++;
        checks++;
        if (imem_addr !== model_pc || pc !== model_pc || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_addr: imem_addr=%h pc=%h instr_valid=%b required %h/%h/0",
                     imem_addr, pc, instr_valid, model_pc, model_pc);
        end
        for (int i = 0; i < fwait; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            exec_done  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (imem_req === 1'b1) req_hi++;
            checks++;
            if (imem_req !== 1'b1 || pc !== model_pc || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_hold: req=%b pc=%h iv=%b required 1/%h/0",
                         imem_req, pc, instr_valid, model_pc);
            end
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        exec_done  = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        exec_done  = 1'b0;
        Branch     = 1'($urandom_range(0, 1));
        Jump       = 1'($urandom_range(0, 1));
        Zero       = 1'($urandom_range(0, 1));
        if (instr_valid === 1'b1) iv_hi++;
        checks++;
        if (instr !== word || Opcode !== word[31:26] || instr_valid !== 1'b1 ||
            imem_req !== 1'b0 || pc !== model_pc) begin
            errors++;
            $display("FAIL exec_entry: instr=%h op=%h iv=%b req=%b pc=%h required %h/%h/1/0/%h",
                     instr, Opcode, instr_valid, imem_req, pc, word, word[31:26], model_pc);
        end
        for (int i = 0; i < ewait; i++) begin
            @(negedge clk);
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            if (instr_valid === 1'b1) iv_hi++;
            checks++;
            if (instr !== word || instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== model_pc) begin
                errors++;
                $display("FAIL exec_hold: instr=%h iv=%b req=%b pc=%h required %h/1/0/%h",
                         instr, instr_valid, imem_req, pc, word, model_pc);
            end
        end
        exec_done = 1'b1;
        Branch    = br;
        Jump      = jp;
        Zero      = zr;
        @(negedge clk);
        exec_done  = 1'b0;
        imem_valid = 1'b0;
        Branch     = 1'($urandom_range(0, 1));
        Jump       = 1'($urandom_range(0, 1));
        Zero       = 1'($urandom_range(0, 1));
        model_pc   = model_next(model_pc, word, br, jp, zr);
        model_ret  = model_ret + 32'd1;
        checks++;
        if (pc !== model_pc || imem_addr !== model_pc || imem_req !== 1'b1 ||
            instr_valid !== 1'b0 || instr !== word) begin
            errors++;
            $display("FAIL retire: pc=%h addr=%h req=%b iv=%b instr=%h required %h/%h/1/0/%h",
                     pc, imem_addr, imem_req, instr_valid, instr, model_pc, model_pc, word);
        end
        checks++;
        if (retired_cnt !== exp_ret()) begin
            errors++;
            $display("FAIL retired_cnt: got %h required %h", retired_cnt, exp_ret());
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0000_0000;
        exec_done  = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        Zero       = 1'b0;
        model_pc   = 32'h0000_0000;
        model_ret  = 32'h0000_0000;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 32'h0 || instr !== 32'h0 || Opcode !== 6'h0 || imem_req !== 1'b0 ||
            imem_addr !== 32'h0 || instr_valid !== 1'b0 || retired_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: pc=%h instr=%h op=%h req=%b addr=%h iv=%b cnt=%h required all 0",
                     pc, instr, Opcode, imem_req, imem_addr, instr_valid, retired_cnt);
        end
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        exec_done  = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: imem_req=%b required 0", imem_req);
        end
        @(negedge clk);
        imem_valid = 1'b0;
        exec_done  = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h instr=%h iv=%b required 1/0/0/0",
                     imem_req, imem_addr, instr, instr_valid);
        end
    endtask

    task automatic test_sequential();
        int rh;
        int ih;
        int t0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_addr !== 32'(i * 4)) begin
                errors++;
                $display("FAIL seq_addr: imem_addr=%h required %h", imem_addr, 32'(i * 4));
            end
            t0 = cyc;
            run_instr({6'b000000, 26'($urandom)}, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 0, 0, rh, ih);
            checks++;
            if (cyc - t0 != 2) begin
                errors++;
                $display("FAIL seq_cycles: took %0d cycles required 2", cyc - t0);
            end
        end
    endtask

    task automatic test_branch();
        int rh;
        int ih;
        logic [31:0] beq;
        beq = {6'b000100, 5'd1, 5'd2, 16'hFFFE};
        run_instr(beq, 1'b1, 1'b0, 1'b1, 0, 0, rh, ih);
        checks++;
        if (imem_addr !== 32'h0000_000C) begin
            errors++;
            $display("FAIL beq_taken: imem_addr=%h required 0000000c", imem_addr);
        end
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 0, rh, ih);
        run_instr(beq, 1'b1, 1'b0, 1'b0, 1, 1, rh, ih);
        checks++;
        if (imem_addr !== 32'h0000_0014) begin
            errors++;
            $display("FAIL beq_not_taken: imem_addr=%h required 00000014", imem_addr);
        end
    endtask

    task automatic test_wrap();
        int rh;
        int ih;
        run_instr({6'b000010, 26'h0}, 1'b0, 1'b1, 1'b0, 0, 0, rh, ih);
        run_instr({6'b000100, 10'd0, 16'hFFFE}, 1'b1, 1'b0, 1'b1, 0, 0, rh, ih);
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_setup: imem_addr=%h required fffffffc", imem_addr);
        end
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 0, 0, rh, ih);
        checks++;
        if (imem_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pc_wrap: imem_addr=%h required 00000000", imem_addr);
        end
    endtask

    task automatic test_stall();
        int rh;
        int ih;
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, 5, 3, rh, ih);
        checks++;
        if (rh != 6) begin
            errors++;
            $display("FAIL stall_req_cycles: got %0d required 6", rh);
        end
        checks++;
        if (ih != 4) begin
            errors++;
            $display("FAIL stall_iv_cycles: got %0d required 4", ih);
        end
    endtask

    task automatic test_mid_reset();
        int rh;
        int ih;
        run_instr({6'b000010, 26'h40}, 1'b0, 1'b1, 1'b0, 0, 0, rh, ih);
        checks++;
        if (imem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL jump_0x100: imem_addr=%h required 00000100", imem_addr);
        end
        imem_valid = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_valid = 1'b0;
        #2;
        rst_n      = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        #1;
        model_pc  = 32'h0000_0000;
        model_ret = 32'h0000_0000;
        checks++;
        if (pc !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || instr !== 32'h0 ||
            retired_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: pc=%h iv=%b req=%b instr=%h cnt=%h required 0/0/0/0/0",
                     pc, instr_valid, imem_req, instr, retired_cnt);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        imem_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_idle: req=%b instr=%h required 0/0", imem_req, instr);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL refetch: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_jump_priority();
        int rh;
        int ih;
        run_instr({6'b000010, 26'h10}, 1'b0, 1'b1, 1'b1, 0, 0, rh, ih);
        for (int k = 0; k < 4096; k++) begin
            run_instr({6'b000100, 10'($urandom), 16'h7FFF}, 1'b1, 1'b0, 1'b1, 0, 0, rh, ih);
        end
        checks++;
        if (imem_addr !== 32'h2000_0040) begin
            errors++;
            $display("FAIL reach_20000040: imem_addr=%h required 20000040", imem_addr);
        end
        run_instr({6'b000010, 26'h0000100}, 1'b1, 1'b1, 1'b1, 0, 0, rh, ih);
        checks++;
        if (imem_addr !== 32'h2000_0400) begin
            errors++;
            $display("FAIL jump_priority: imem_addr=%h required 20000400", imem_addr);
        end
    endtask

    task automatic test_random();
        int rh;
        int ih;
        for (int n = 0; n < 200; n++) begin
            run_instr($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), rh, ih);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_stall();
        test_mid_reset();
        test_jump_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
